// File: rtl/sobel_stream.sv
// Streaming Sobel edge-magnitude engine.
// Takes raster-order gray pixels one beat at a time and keeps the two previous
// lines in line buffers. It shifts a 3x3 window and emits |h|+|v| (optionally
// halved, then saturated) for every interior pixel, marking the frame's last output.
module sobel_stream #(
   parameter int GRAY_DATA_WIDTH = 8,
   parameter int IMG_WIDTH       = 720,
   parameter int IMG_HEIGHT      = 540
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       mode,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [GRAY_DATA_WIDTH-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [GRAY_DATA_WIDTH-1:0] out_data,
   output logic                       out_last
);

   localparam int DATA_W = GRAY_DATA_WIDTH;
   localparam int SUM_W  = DATA_W + 3;
   localparam int CW     = $clog2(IMG_WIDTH);
   localparam int RW     = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   // Zero-extend a pixel into the signed gradient domain.
   function automatic logic signed [SUM_W-1:0] ext_f(input logic [DATA_W-1:0] x);
      return $signed({3'b000, x});
   endfunction

   // Absolute value; the most negative code is unreachable for Sobel sums.
   function automatic logic [SUM_W-1:0] abs_f(input logic signed [SUM_W-1:0] x);
      logic signed [SUM_W-1:0] n;
      n = -x;
      return x[SUM_W-1] ? $unsigned(n) : $unsigned(x);
   endfunction

   // Halved magnitude in mode 0, full magnitude in mode 1 (truncating shift).
   function automatic logic [SUM_W-1:0] scale_f(input logic [SUM_W-1:0] s, input logic full);
      return full ? s : (s >> 1);
   endfunction

   // Clamp to the output pixel range instead of dropping high bits.
   function automatic logic [DATA_W-1:0] sat_f(input logic [SUM_W-1:0] m);
      return (|m[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : m[DATA_W-1:0];
   endfunction

   // Position of the pixel currently presented at the input.
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by column.
   logic [DATA_W-1:0] lb1 [IMG_WIDTH];
   logic [DATA_W-1:0] lb2 [IMG_WIDTH];

   // Two older window columns; the newest column comes straight from the buffers.
   logic [DATA_W-1:0] left_p0   [3];
   logic [DATA_W-1:0] centre_p0 [3];

   logic                     accept_p0;
   logic                     win_done_p0;
   logic                     last_pix_p0;
   logic [DATA_W-1:0]        top_p0;
   logic [DATA_W-1:0]        mid_p0;
   logic signed [SUM_W-1:0]  h_p0;
   logic signed [SUM_W-1:0]  v_p0;
   logic [SUM_W-1:0]         s_p0;
   logic [DATA_W-1:0]        mag_p0;

   logic                     vld_p1;
   logic [DATA_W-1:0]        data_p1;
   logic                     last_p1;

   assign in_ready  = !vld_p1 || out_ready;
   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_last  = last_p1;

   // ---- stage p0: accepted beat, window assembly and gradient arithmetic ----
   // Window taps, gradients and saturated magnitude for the beat on the input.
   always_comb begin
      accept_p0   = in_valid && in_ready;
      win_done_p0 = (row >= RW'(2)) && (col >= CW'(2));
      last_pix_p0 = (row == ROW_LAST) && (col == COL_LAST);
      top_p0      = lb2[col];
      mid_p0      = lb1[col];
      // h: bottom row minus top row; v: right column minus left column.
      h_p0 = ext_f(left_p0[2]) + ext_f(centre_p0[2]) + ext_f(centre_p0[2]) + ext_f(in_data)
           - ext_f(left_p0[0]) - ext_f(centre_p0[0]) - ext_f(centre_p0[0]) - ext_f(top_p0);
      v_p0 = ext_f(top_p0) + ext_f(mid_p0) + ext_f(mid_p0) + ext_f(in_data)
           - ext_f(left_p0[0]) - ext_f(left_p0[1]) - ext_f(left_p0[1]) - ext_f(left_p0[2]);
      s_p0   = abs_f(h_p0) + abs_f(v_p0);
      mag_p0 = sat_f(scale_f(s_p0, mode));
   end

   // Raster position counters, wrapping at end of line and end of frame.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col <= '0;
         row <= '0;
      end else if (accept_p0) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Line buffers and window shift; stale contents are masked by the row gating.
   always_ff @(posedge clock) begin
      if (accept_p0) begin
         lb2[col]     <= mid_p0;
         lb1[col]     <= in_data;
         left_p0[0]   <= centre_p0[0];
         left_p0[1]   <= centre_p0[1];
         left_p0[2]   <= centre_p0[2];
         centre_p0[0] <= top_p0;
         centre_p0[1] <= mid_p0;
         centre_p0[2] <= in_data;
      end
   end

   // ---- stage p1: single-slot output register ----
   // Load a result on each window-completing beat; drop valid once it is taken.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (accept_p0) begin
         vld_p1 <= win_done_p0;
         if (win_done_p0) begin
            data_p1 <= mag_p0;
            last_p1 <= last_pix_p0;
         end
      end else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream on a 5x5 frame: directed images, back-to-back frames,
// randomized valid/ready with random pixels, and a mid-frame reset.
module tb_sobel_stream;

   localparam int W  = 8;
   localparam int IW = 5;
   localparam int IH = 5;
   localparam int N  = IW * IH;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         mode = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_last;

   int ncmp = 0;
   int nerr = 0;
   int img [N];
   int exp_d [$];
   int exp_l [$];
   int got_d [$];
   int got_l [$];

   logic         stall_prev = 1'b0;
   logic [W-1:0] d_prev = '0;
   logic         l_prev = 1'b0;

   always #5 clock = ~clock;

   sobel_stream #(
      .GRAY_DATA_WIDTH(W),
      .IMG_WIDTH      (IW),
      .IMG_HEIGHT     (IH)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .mode     (mode),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last)
   );

   task automatic chk(input string tag, input int obs, input int expv);
      ncmp++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int px(input int r, input int c);
      return img[r*IW + c];
   endfunction

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   // Reference: classic Sobel on every interior pixel of img, in raster order.
   task automatic model(input logic md);
      int h, v, s, m;
      for (int r = 1; r < IH - 1; r++) begin
         for (int c = 1; c < IW - 1; c++) begin
            h = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1))
              - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
            v = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1))
              - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
            s = iabs(h) + iabs(v);
            m = md ? s : s / 2;
            if (m > 255) m = 255;
            exp_d.push_back(m);
            exp_l.push_back((r == IH-2 && c == IW-2) ? 1 : 0);
         end
      end
   endtask

   // Output monitor: collect handshaken results and check hold-while-stalled.
   always @(negedge clock) begin
      if (!reset_n) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), int'(d_prev));
            chk("stall_last", int'(out_last), int'(l_prev));
         end
         if (out_valid && !out_ready) chk("stall_in_ready", int'(in_ready), 0);
         if (out_valid && out_ready) begin
            got_d.push_back(int'(out_data));
            got_l.push_back(int'(out_last));
         end
         stall_prev <= out_valid && !out_ready;
         d_prev     <= out_data;
         l_prev     <= out_last;
      end
   end

   // Push n pixels of img; vp/rp are percent chances of in_valid/out_ready.
   task automatic send_frame(input int n, input logic md, input int vp, input int rp, input bit lat);
      int  idx   = 0;
      int  guard = 0;
      bit  pend  = 0;
      while (idx < n) begin
         @(posedge clock);
         #1;
         if (idx == 0) mode = md;
         in_valid  = ($urandom_range(99) < vp);
         in_data   = W'(img[idx]);
         out_ready = ($urandom_range(99) < rp);
         @(negedge clock);
         if (pend) begin
            chk("lat_valid_after", int'(out_valid), 1);
            pend = 0;
         end
         if (in_valid && in_ready) begin
            if (lat && idx == 2*IW + 2) begin
               chk("lat_valid_before", int'(out_valid), 0);
               pend = 1;
            end
            idx++;
         end
         guard++;
         if (guard > 4000) begin
            chk("timeout_beats", idx, n);
            break;
         end
      end
   endtask

   task automatic drain();
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic compare(input string name);
      chk({name, "_count"}, got_d.size(), exp_d.size());
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         chk($sformatf("%s_data%0d", name, i), got_d[i], exp_d[i]);
         chk($sformatf("%s_last%0d", name, i), got_l[i], exp_l[i]);
      end
      exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clock);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // horizontal ramp 10*col, halved: nine outputs of 40, latency check
      for (int i = 0; i < N; i++) img[i] = 10 * (i % IW);
      model(1'b0);
      send_frame(N, 1'b0, 100, 100, 1'b1);
      drain();
      compare("ramp10");

      // ramp 40*col: halved then full (saturating) back-to-back
      for (int i = 0; i < N; i++) img[i] = 40 * (i % IW);
      model(1'b0);
      send_frame(N, 1'b0, 100, 100, 1'b0);
      model(1'b1);
      send_frame(N, 1'b1, 100, 100, 1'b0);
      drain();
      compare("ramp40");

      // horizontal step: row 0 dark, rest bright
      for (int i = 0; i < N; i++) img[i] = (i < IW) ? 0 : 255;
      model(1'b0);
      send_frame(N, 1'b0, 100, 100, 1'b0);
      drain();
      compare("step");

      // flat 200 over two back-to-back frames
      for (int i = 0; i < N; i++) img[i] = 200;
      model(1'b0);
      send_frame(N, 1'b0, 100, 100, 1'b0);
      model(1'b0);
      send_frame(N, 1'b0, 100, 100, 1'b0);
      drain();
      compare("flat");

      // random pixels, random mode, random valid/ready, frames back-to-back
      for (int f = 0; f < 4; f++) begin
         logic md;
         md = 1'($urandom_range(1));
         for (int i = 0; i < N; i++) img[i] = $urandom_range(255);
         model(md);
         send_frame(N, md, 60, 55, 1'b0);
      end
      drain();
      compare("random");

      // reset in the middle of row 3
      for (int i = 0; i < N; i++) img[i] = $urandom_range(255);
      send_frame(3*IW + 3, 1'b0, 100, 100, 1'b0);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      chk("pre_reset_valid", int'(out_valid), 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_out_last", int'(out_last), 0);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      got_d.delete(); got_l.delete();
      for (int i = 0; i < N; i++) img[i] = $urandom_range(255);
      model(1'b0);
      send_frame(N, 1'b0, 100, 100, 1'b0);
      drain();
      compare("after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
